matmul_sequencer_module: RTL and testbench

MATMUL_SEQUENCER_MODULE -- requirements
Module: matmul_sequencer_module

---
 rtl/matmul_sequencer_module_if.sv | 52 +++++
 rtl/matmul_sequencer_module.sv | 193 +++++++++++++++++++
 tb/tb_matmul_sequencer_module.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/matmul_sequencer_module_if.sv
// Purpose: bundles the sequencer's control, multiplier and scratchpad signals.
// Latency: none, wiring only; the slave modport is the sequencer itself.
// Backpressure: none; the multiplier signals completion with mul_finish_i.
interface matmul_sequencer_module_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;

    // Host control
    logic                                  go_i;
    logic                                  abort_i;
    logic [1:0]                            n_dim_i;
    logic [1:0]                            k_dim_i;
    logic [1:0]                            m_dim_i;
    logic                                  mode_i;
    logic [1:0]                            bank_i;
    // Multiplier side
    logic                                  mul_finish_i;
    logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0]  mul_c_i;
    logic [MAX_DIM*MAX_DIM-1:0]            mul_flags_i;
    logic                                  mul_start_o;
    logic                                  mul_mode_o;
    logic [1:0]                            mul_n_o;
    logic [1:0]                            mul_k_o;
    logic [1:0]                            mul_m_o;
    // Scratchpad write port
    logic                                  sp_wr_en_o;
    logic [3:0]                            sp_addr_o;
    logic [MAX_DIM*BUS_WIDTH-1:0]          sp_data_o;
    // Status
    logic                                  busy_o;
    logic                                  done_o;
    logic [MAX_DIM*MAX_DIM-1:0]            flags_o;
    logic                                  error_o;

    modport slave (
        input  go_i, abort_i, n_dim_i, k_dim_i, m_dim_i, mode_i, bank_i,
               mul_finish_i, mul_c_i, mul_flags_i,
        output mul_start_o, mul_mode_o, mul_n_o, mul_k_o, mul_m_o,
               sp_wr_en_o, sp_addr_o, sp_data_o,
               busy_o, done_o, flags_o, error_o
    );

    modport master (
        output go_i, abort_i, n_dim_i, k_dim_i, m_dim_i, mode_i, bank_i,
               mul_finish_i, mul_c_i, mul_flags_i,
        input  mul_start_o, mul_mode_o, mul_n_o, mul_k_o, mul_m_o,
               sp_wr_en_o, sp_addr_o, sp_data_o,
               busy_o, done_o, flags_o, error_o
    );
endinterface

// File: rtl/matmul_sequencer_module.sv
// Purpose: runs one matrix multiply, then streams the result rows into a scratchpad bank.
// Latency: go accepted -> done_o = RUN cycles + (m+1) write cycles + 1; all outputs registered.
// Backpressure: none; the RUN phase is bounded by a TIMEOUT watchdog, and abort_i cancels any phase.
module matmul_sequencer_module #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16,
    parameter int TIMEOUT    = 16
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    matmul_sequencer_module_if.slave   bus
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int WORD_W  = MAX_DIM * BUS_WIDTH;
    localparam int RES_W   = MAX_DIM * WORD_W;
    localparam int FLG_W   = MAX_DIM * MAX_DIM;
    localparam int WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [1:0]        word_q, word_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic              start_q, start_d;
    logic              mode_q, mode_d;
    logic [1:0]        n_q, n_d, k_q, k_d, m_q, m_d, bank_q, bank_d;
    logic              wr_en_q, wr_en_d;
    logic [3:0]        addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [FLG_W-1:0]  flags_q, flags_d;
    logic              error_q, error_d;

    logic [WD_W-1:0]   wd_inc;
    logic [1:0]        word_nxt;

    assign wd_inc   = wd_q + 1'b1;
    assign word_nxt = word_q + 2'd1;

    // Row words beyond MAX_DIM have no result data behind them and read as zero.
    function automatic logic [WORD_W-1:0] pick_word(input logic [RES_W-1:0] vec,
                                                    input logic [1:0]       idx);
        pick_word = '0;
        for (int i = 0; i < MAX_DIM; i++) begin
            if (int'(idx) == i) pick_word = vec[i*WORD_W +: WORD_W];
        end
    endfunction

    // Next-state and registered-output logic; abort beats finish beats timeout beats go.
    always_comb begin
        state_d  = state_q;
        wd_d     = wd_q;
        word_d   = word_q;
        result_d = result_q;
        start_d  = start_q;
        mode_d   = mode_q;
        n_d      = n_q;
        k_d      = k_q;
        m_d      = m_q;
        bank_d   = bank_q;
        busy_d   = busy_q;
        flags_d  = flags_q;
        error_d  = error_q;
        wr_en_d  = 1'b0;
        addr_d   = '0;
        data_d   = '0;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.go_i && !bus.abort_i) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    n_d     = bus.n_dim_i;
                    k_d     = bus.k_dim_i;
                    m_d     = bus.m_dim_i;
                    mode_d  = bus.mode_i;
                    bank_d  = bus.bank_i;
                    flags_d = '0;
                    error_d = 1'b0;
                    wd_d    = '0;
                end
            end
            S_RUN: begin
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                    start_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (bus.mul_finish_i) begin
                    // Word 0 is issued on the capture edge, straight from the bus.
                    state_d  = S_WRITE;
                    start_d  = 1'b0;
                    result_d = bus.mul_c_i;
                    flags_d  = flags_q | bus.mul_flags_i;
                    word_d   = 2'd0;
                    wr_en_d  = 1'b1;
                    addr_d   = {bank_q, 2'd0};
                    data_d   = pick_word(bus.mul_c_i, 2'd0);
                end else if (wd_inc == WD_LIMIT) begin
                    state_d = S_DONE;
                    start_d = 1'b0;
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    wd_d    = wd_inc;
                end else begin
                    wd_d = wd_inc;
                end
            end
            S_WRITE: begin
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (word_q == m_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    word_d  = word_nxt;
                    wr_en_d = 1'b1;
                    addr_d  = {bank_q, word_nxt};
                    data_d  = pick_word(result_q, word_nxt);
                end
            end
            S_DONE: begin
                // done_o lasts one cycle whether or not abort_i is raised here.
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                start_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            wd_q     <= '0;
            word_q   <= '0;
            result_q <= '0;
            start_q  <= 1'b0;
            mode_q   <= 1'b0;
            n_q      <= '0;
            k_q      <= '0;
            m_q      <= '0;
            bank_q   <= '0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flags_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            word_q   <= word_d;
            result_q <= result_d;
            start_q  <= start_d;
            mode_q   <= mode_d;
            n_q      <= n_d;
            k_q      <= k_d;
            m_q      <= m_d;
            bank_q   <= bank_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            flags_q  <= flags_d;
            error_q  <= error_d;
        end
    end

    assign bus.mul_start_o = start_q;
    assign bus.mul_mode_o  = mode_q;
    assign bus.mul_n_o     = n_q;
    assign bus.mul_k_o     = k_q;
    assign bus.mul_m_o     = m_q;
    assign bus.sp_wr_en_o  = wr_en_q;
    assign bus.sp_addr_o   = addr_q;
    assign bus.sp_data_o   = data_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.flags_o     = flags_q;
    assign bus.error_o     = error_q;
endmodule

// File: tb/tb_matmul_sequencer_module.sv
// Purpose: scoreboard bench for matmul_sequencer_module with randomized transactions.
// Latency: expected write/done events carry the absolute cycle they must appear in.
// Backpressure: none; abort and reset are injected at chosen cycles.
module tb_matmul_sequencer_module;
    localparam int DW = 8;
    localparam int BW = 16;
    localparam int MD = BW / DW;
    localparam int WW = MD * BW;
    localparam int RW = MD * WW;
    localparam int FW = MD * MD;
    localparam int TO = 16;

    typedef struct {
        bit              is_done;
        int              cyc;
        logic [3:0]      addr;
        logic [WW-1:0]   data;
        logic [FW-1:0]   flags;
        logic            err;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    ev_t  exp_q[$];
    ev_t  mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matmul_sequencer_module_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) bus();

    matmul_sequencer_module #(.DATA_WIDTH(DW), .BUS_WIDTH(BW), .TIMEOUT(TO)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every write strobe or done pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.sp_wr_en_o || bus.done_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: wr_en %0b done %0b addr 0x%0h at cycle %0d, expected none",
                         bus.sp_wr_en_o, bus.done_o, bus.sp_addr_o, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind_done", 64'(bus.done_o), 64'(mon_e.is_done));
                check("event_cycle", 64'(cyc), 64'(mon_e.cyc));
                if (mon_e.is_done) begin
                    check("done_flags", 64'(bus.flags_o), 64'(mon_e.flags));
                    check("done_error", 64'(bus.error_o), 64'(mon_e.err));
                end else begin
                    check("wr_addr", 64'(bus.sp_addr_o), 64'(mon_e.addr));
                    check("wr_data", 64'(bus.sp_data_o), 64'(mon_e.data));
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(bus.busy_o),      64'd0);
        check({tag, "_start"}, 64'(bus.mul_start_o), 64'd0);
        check({tag, "_wr_en"}, 64'(bus.sp_wr_en_o),  64'd0);
        check({tag, "_done"},  64'(bus.done_o),      64'd0);
        check({tag, "_flags"}, 64'(bus.flags_o),     64'd0);
        check({tag, "_error"}, 64'(bus.error_o),     64'd0);
        check({tag, "_dims"},  64'({bus.mul_n_o, bus.mul_k_o, bus.mul_m_o, bus.mul_mode_o}), 64'd0);
        check({tag, "_addr_data"}, 64'({bus.sp_addr_o, bus.sp_data_o}), 64'd0);
    endtask

    // One transaction. fd: RUN cycle carrying mul_finish_i (outside 1..TO means never in time).
    // kill_kind 1 = abort, 2 = reset, applied at relative edge kill_at (0 = none).
    task automatic run_txn(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m,
                           input logic mode, input logic [1:0] bank, input int fd,
                           input logic [RW-1:0] res, input logic [FW-1:0] fl,
                           input int kill_at, input int kill_kind, input bit go_noise);
        int t0, d_cyc, endr, wait_n;
        bit timed_out;
        logic [FW-1:0] fl_exp;
        logic err_exp;
        ev_t e;

        @(negedge clk);
        bus.n_dim_i = n; bus.k_dim_i = k; bus.m_dim_i = m;
        bus.mode_i = mode; bus.bank_i = bank; bus.mul_c_i = res;
        bus.go_i = 1'b1;
        t0 = cyc + 1;
        timed_out = (fd < 1) || (fd > TO);

        // Reference model: list of events with the cycle each one must be seen in.
        if (!timed_out) begin
            for (int w = 0; w <= int'(m); w++) begin
                e.is_done = 1'b0;
                e.cyc     = t0 + fd + w;
                e.addr    = {bank, w[1:0]};
                e.data    = (w < MD) ? res[w*WW +: WW] : '0;
                e.flags   = '0;
                e.err     = 1'b0;
                if (kill_at == 0 || e.cyc < t0 + kill_at) exp_q.push_back(e);
            end
            d_cyc = t0 + fd + int'(m) + 1;
            fl_exp = fl; err_exp = 1'b0;
        end else begin
            d_cyc = t0 + TO;
            fl_exp = '0; err_exp = 1'b1;
        end
        e.is_done = 1'b1; e.cyc = d_cyc; e.addr = '0; e.data = '0;
        e.flags = fl_exp; e.err = err_exp;
        if (kill_at == 0 || d_cyc < t0 + kill_at) exp_q.push_back(e);
        endr = (kill_at > 0) ? kill_at : (d_cyc - t0 + 1);

        @(negedge clk);
        bus.go_i = 1'b0;
        check("run_busy",  64'(bus.busy_o),      64'd1);
        check("run_start", 64'(bus.mul_start_o), 64'd1);
        check("run_latched", 64'({bus.mul_n_o, bus.mul_k_o, bus.mul_m_o, bus.mul_mode_o}),
              64'({n, k, m, mode}));
        check("run_status_cleared", 64'({bus.flags_o, bus.error_o}), 64'd0);

        for (int r = 1; r <= endr; r++) begin
            bus.n_dim_i = 2'($urandom); bus.k_dim_i = 2'($urandom);
            bus.m_dim_i = 2'($urandom); bus.mode_i = 1'($urandom);
            bus.bank_i = 2'($urandom);
            bus.mul_finish_i = (r == fd);
            bus.mul_flags_i  = (r == fd) ? fl : FW'($urandom);
            bus.abort_i      = (kill_kind == 1) && (r == kill_at);
            rst_n            = !((kill_kind == 2) && (r == kill_at));
            bus.go_i         = go_noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        bus.go_i = 1'b0; bus.abort_i = 1'b0; bus.mul_finish_i = 1'b0; rst_n = 1'b1;

        if (kill_kind == 2 && kill_at > 0) begin
            check_all_zero("after_reset");
        end else if (kill_kind == 1 && kill_at > 0) begin
            check("abort_busy",  64'(bus.busy_o),      64'd0);
            check("abort_start", 64'(bus.mul_start_o), 64'd0);
            check("abort_flags", 64'(bus.flags_o),
                  64'((!timed_out && fd < kill_at) ? fl : '0));
            check("abort_error", 64'(bus.error_o), 64'(timed_out && kill_at > TO));
        end else begin
            check("end_busy",  64'(bus.busy_o),  64'd0);
            check("end_flags", 64'(bus.flags_o), 64'(fl_exp));
            check("end_error", 64'(bus.error_o), 64'(err_exp));
            check("end_latched", 64'({bus.mul_n_o, bus.mul_k_o, bus.mul_m_o, bus.mul_mode_o}),
                  64'({n, k, m, mode}));
        end

        wait_n = 0;
        while (exp_q.size() > 0 && wait_n < 40) begin
            @(negedge clk);
            wait_n++;
        end
        check("events_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int fd, m, kat, kk, span;
        logic [RW-1:0] rv;
        bus.go_i = 1'b0; bus.abort_i = 1'b0; bus.n_dim_i = '0; bus.k_dim_i = '0;
        bus.m_dim_i = '0; bus.mode_i = 1'b0; bus.bank_i = '0; bus.mul_finish_i = 1'b0;
        bus.mul_c_i = '0; bus.mul_flags_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // Two-word result into bank 2, finish five cycles after go.
        run_txn(2'd1, 2'd1, 2'd1, 1'b0, 2'd2, 5, 64'h0004_0003_0002_0001, 4'b0000, 0, 0, 1'b0);
        // Single-word write.
        run_txn(2'd0, 2'd1, 2'd0, 1'b1, 2'd1, 3, 64'hdead_beef_1234_5678, 4'b0001, 0, 0, 1'b0);
        // Finish never comes: watchdog timeout.
        run_txn(2'd1, 2'd0, 2'd1, 1'b0, 2'd3, 0, 64'h1111_2222_3333_4444, 4'b0000, 0, 0, 1'b0);
        // Finish on the very edge the watchdog would expire, then one cycle too late.
        run_txn(2'd1, 2'd1, 2'd1, 1'b1, 2'd0, TO, 64'h0a0b_0c0d_0e0f_1011, 4'b1000, 0, 0, 1'b0);
        run_txn(2'd1, 2'd1, 2'd1, 1'b1, 2'd0, TO + 1, 64'h0a0b_0c0d_0e0f_1011, 4'b1000, 0, 0, 1'b0);
        // Abort while word 0 is on the scratchpad port.
        run_txn(2'd1, 2'd1, 2'd1, 1'b0, 2'd2, 4, 64'h5555_6666_7777_8888, 4'b0010, 5, 1, 1'b0);
        // Stray go pulses during RUN and DONE; flags must survive to the end.
        run_txn(2'd1, 2'd0, 2'd1, 1'b0, 2'd1, 6, 64'h9999_aaaa_bbbb_cccc, 4'b0100, 0, 0, 1'b1);
        repeat (3) @(negedge clk);
        check("flags_hold_idle", 64'(bus.flags_o), 64'h4);
        // Abort and go together in IDLE: abort wins.
        bus.go_i = 1'b1; bus.abort_i = 1'b1;
        @(negedge clk);
        bus.go_i = 1'b0; bus.abort_i = 1'b0;
        check("abort_beats_go", 64'({bus.busy_o, bus.mul_start_o}), 64'd0);
        // Reset mid-RUN, then a normal run.
        run_txn(2'd1, 2'd1, 2'd1, 1'b1, 2'd3, 10, 64'h0123_4567_89ab_cdef, 4'b0011, 3, 2, 1'b0);
        run_txn(2'd0, 2'd0, 2'd1, 1'b0, 2'd3, 2, 64'hfeed_face_cafe_f00d, 4'b0000, 0, 0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            m  = $urandom_range(0, MD - 1);
            fd = $urandom_range(0, TO + 2);
            span = (fd >= 1 && fd <= TO) ? fd + m + 2 : TO + 1;
            kk  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            kat = (kk != 0) ? $urandom_range(1, span) : 0;
            rv  = {$urandom, $urandom};
            run_txn(2'($urandom), 2'($urandom), 2'(m), 1'($urandom), 2'($urandom), fd, rv,
                    FW'($urandom), kat, kk, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
